// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes the PS/2 pair, deframes 11-bit frames with
// odd-parity/stop checking and tracks make/break codes into the held key code.
module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error,
    output logic [7:0] kb_code,
    output logic       key_down
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Synchronizer flops reset to 1 so reset release never looks like a falling edge
    logic clk_s1_reg, clk_s2_reg, clk_prev_reg;
    logic data_s1_reg, data_s2_reg;
    logic fall;

    state_t          state_reg, state_next;
    logic [7:0]      shift_reg, shift_next;
    logic [2:0]      bit_cnt_reg, bit_cnt_next;
    logic            parity_reg, parity_next;
    logic [TW-1:0]   timeout_reg, timeout_next;
    logic [7:0]      scan_code_reg, scan_code_next;
    logic            scan_valid_reg, scan_valid_next;
    logic            frame_error_reg, frame_error_next;
    logic [7:0]      kb_code_reg, kb_code_next;
    logic            key_down_reg, key_down_next;
    logic            break_pending_reg, break_pending_next;

    assign fall = clk_prev_reg & ~clk_s2_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_reg        <= 1'b1;
            clk_s2_reg        <= 1'b1;
            clk_prev_reg      <= 1'b1;
            data_s1_reg       <= 1'b1;
            data_s2_reg       <= 1'b1;
            state_reg         <= IDLE;
            shift_reg         <= 8'h00;
            bit_cnt_reg       <= 3'd0;
            parity_reg        <= 1'b0;
            timeout_reg       <= '0;
            scan_code_reg     <= 8'h00;
            scan_valid_reg    <= 1'b0;
            frame_error_reg   <= 1'b0;
            kb_code_reg       <= 8'h00;
            key_down_reg      <= 1'b0;
            break_pending_reg <= 1'b0;
        end else begin
            clk_s1_reg        <= ps2_clk;
            clk_s2_reg        <= clk_s1_reg;
            clk_prev_reg      <= clk_s2_reg;
            data_s1_reg       <= ps2_data;
            data_s2_reg       <= data_s1_reg;
            state_reg         <= state_next;
            shift_reg         <= shift_next;
            bit_cnt_reg       <= bit_cnt_next;
            parity_reg        <= parity_next;
            timeout_reg       <= timeout_next;
            scan_code_reg     <= scan_code_next;
            scan_valid_reg    <= scan_valid_next;
            frame_error_reg   <= frame_error_next;
            kb_code_reg       <= kb_code_next;
            key_down_reg      <= key_down_next;
            break_pending_reg <= break_pending_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        shift_next         = shift_reg;
        bit_cnt_next       = bit_cnt_reg;
        parity_next        = parity_reg;
        timeout_next       = timeout_reg;
        scan_code_next     = scan_code_reg;
        scan_valid_next    = 1'b0;
        frame_error_next   = 1'b0;
        kb_code_next       = kb_code_reg;
        key_down_next      = key_down_reg;
        break_pending_next = break_pending_reg;

        if (state_reg == IDLE || fall) begin
            timeout_next = '0;
        end else begin
            timeout_next = timeout_reg + 1'b1;
        end

        if (fall) begin
            unique case (state_reg)
                IDLE: begin
                    if (!data_s2_reg) begin
                        shift_next   = 8'h00;
                        bit_cnt_next = 3'd0;
                        state_next   = DATA;
                    end
                end
                DATA: begin
                    shift_next   = {data_s2_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    parity_next = data_s2_reg;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if (data_s2_reg && ((^shift_reg) ^ parity_reg)) begin
                        scan_code_next  = shift_reg;
                        scan_valid_next = 1'b1;
                        if (shift_reg == CODE_EXT) begin
                            // extended prefix carries no key state of its own
                        end else if (shift_reg == CODE_BREAK) begin
                            break_pending_next = 1'b1;
                        end else if (break_pending_reg) begin
                            break_pending_next = 1'b0;
                            // only releasing the key we are holding clears it
                            if (shift_reg == kb_code_reg) begin
                                kb_code_next  = 8'h00;
                                key_down_next = 1'b0;
                            end
                        end else begin
                            kb_code_next  = shift_reg;
                            key_down_next = 1'b1;
                        end
                    end else begin
                        frame_error_next   = 1'b1;
                        break_pending_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state_reg != IDLE && timeout_reg == TIMEOUT_LAST) begin
            state_next         = IDLE;
            frame_error_next   = 1'b1;
            break_pending_next = 1'b0;
        end
    end

    assign scan_code   = scan_code_reg;
    assign scan_valid  = scan_valid_reg;
    assign frame_error = frame_error_reg;
    assign kb_code     = kb_code_reg;
    assign key_down    = key_down_reg;

endmodule
